sphere_seq_scheduler: RTL
=========================

// Module: sphere_seq_scheduler
// PURPOSE
//  Run sequencer for the sphere_fsm_32bit_simple point generator. Takes one run command
//  (first index, point count, base pair) and issues one core start per index.
//  Captures each core result and streams it out on a valid/ready port tagged with its index.
//  Sits between the host/CSR side and a single core instance, which it owns exclusively.
// PARAMETERS
//  W_CNT   16  width of the run point-count field; max run length 2^W_CNT-1
// PORTS
//  clk          in   1      system clock, all logic on rising edge
//  rst_n        in   1      asynchronous active-low reset
//  cmd_valid    in   1      run command present
//  cmd_ready    out  1      command accepted when cmd_valid&cmd_ready; high only in IDLE
//  cmd_k0       in   32     first index k of the run
//  cmd_count    in   W_CNT  number of points in the run
//  cmd_base0    in   2      base_sel0 for the run (0..3 -> base 2..5 coding as core)
//  cmd_base1    in   2      base_sel1 for the run
//  core_start   out  1      one-cycle start pulse to core
//  core_k       out  32     index presented to core; stable from start until done
//  core_base0   out  2      registered cmd_base0
//  core_base1   out  2      registered cmd_base1
//  core_ready   in   1      core idle
//  core_done    in   1      core result valid
//  core_x/y/z   in   32     core results, Q16.16 signed
//  out_valid    out  1      result beat valid
//  out_ready    in   1      downstream accepts beat
//  out_x/y/z    out  32     captured results
//  out_k        out  32     index of this beat
//  out_last     out  1      beat is the final point of the run
//  run_done     out  1      one-cycle pulse: run finished (after last beat accepted)
// BEHAVIOUR
//  Reset: state=IDLE; cmd_ready=1 after reset release; core_start, out_valid, out_last,
//   run_done = 0; core_k, core_base*, out_x/y/z, out_k = 0; remaining count = 0.
//  FSM: IDLE, ISSUE, WAIT, EMIT, FIN.
//  IDLE: on cmd accept latch k0, count, bases. count==0 -> FIN (no core_start); else ISSUE.
//  ISSUE: core_k/bases already driven; when core_ready=1 assert core_start for exactly one
//   cycle and go WAIT; core_ready=0 -> stay, core_start=0.
//  WAIT: first cycle with core_done=1 capture core_x/y/z into out_*, out_k<=core_k,
//   out_last<=(remaining==1), out_valid<=1 -> EMIT. core_done outside WAIT is ignored.
//  EMIT: out_* held stable while out_valid&!out_ready. On accept: out_valid<=0;
//   remaining-1; if last -> FIN else core_k<=core_k+1 -> ISSUE.
//  FIN: run_done=1 for one cycle -> IDLE (cmd_ready=1 next cycle).
//  Min latency cmd accept -> first core_start: 1 cycle (core_ready high).
//  core_k increments modulo 2^32: 32'hFFFF_FFFF is followed by 0, no flag.
//  Back-to-back runs: next cmd accepted earliest the cycle after run_done.
//  cmd_valid outside IDLE: not accepted, no effect; cmd fields sampled only on accept.
//  Async reset mid-run: immediate return to reset values; in-flight core result discarded;
//   core shares rst_n so no residual start is owed.
// CONFIGURATION
//  SPHERE_SCHED_ABORT_EN defined: adds input port cmd_abort (1b). cmd_abort=1 in ISSUE
//   -> FIN with no core_start; in WAIT -> wait core_done, discard result, FIN;
//   in EMIT -> finish current beat with out_last forced 1, then FIN. Ignored in IDLE/FIN.
//   run_done pulses once per run either way.
//  Not defined: no cmd_abort port; runs always complete cmd_count points.
// TESTING
//  k0=1,count=3,bases(0,1), out_ready=1 -> 3 beats out_k=1,2,3; beat1 x=0xFFFF8000 (-0.5)
//   y~0x0000DDB4 (0.866) z=0; out_last only on k=3; single run_done pulse.
//  count=0 -> zero core_start pulses, zero beats, run_done 1 cycle after accept+1.
//  core_ready held low 10 cycles in ISSUE -> core_start stays 0, pulses once when high.
//  out_ready low 20 cycles during EMIT -> out_* stable, no further core_start until accept.
//  k0=32'hFFFF_FFFF,count=2 -> out_k = FFFF_FFFF then 0000_0000, out_last on second.
//  rst_n low during WAIT -> all outputs at reset values same cycle; new run then works.
//  ABORT_EN: cmd_abort in WAIT of point 2 of 5 -> 1 beat emitted, run_done, back to IDLE.

Source files
------------

// File: rtl/sphere_seq_scheduler.sv
// Run sequencer for one sphere point-generator core: issues one core start per index, streams results out.
// Optional abort input enabled by defining SPHERE_SCHED_ABORT_EN.
module sphere_seq_scheduler #(
   parameter int unsigned W_CNT = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [31:0]      cmd_k0,
   input  logic [W_CNT-1:0] cmd_count,
   input  logic [1:0]       cmd_base0,
   input  logic [1:0]       cmd_base1,
`ifdef SPHERE_SCHED_ABORT_EN
   input  logic             cmd_abort,
`endif
   output logic             core_start,
   output logic [31:0]      core_k,
   output logic [1:0]       core_base0,
   output logic [1:0]       core_base1,
   input  logic             core_ready,
   input  logic             core_done,
   input  logic [31:0]      core_x,
   input  logic [31:0]      core_y,
   input  logic [31:0]      core_z,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_x,
   output logic [31:0]      out_y,
   output logic [31:0]      out_z,
   output logic [31:0]      out_k,
   output logic             out_last,
   output logic             run_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_EMIT,
      S_FIN
   } state_t;

   state_t           state_q, state_d;
   logic             cmd_ready_q, cmd_ready_d;
   logic             core_start_q, core_start_d;
   logic [31:0]      core_k_q, core_k_d;
   logic [1:0]       base0_q, base0_d;
   logic [1:0]       base1_q, base1_d;
   logic [W_CNT-1:0] remaining_q, remaining_d;
   logic [31:0]      out_x_q, out_x_d;
   logic [31:0]      out_y_q, out_y_d;
   logic [31:0]      out_z_q, out_z_d;
   logic [31:0]      out_k_q, out_k_d;
   logic             out_valid_q, out_valid_d;
   logic             out_last_q, out_last_d;
   logic             run_done_q, run_done_d;
   logic             abort_q, abort_d;
   logic             abort_req;

`ifdef SPHERE_SCHED_ABORT_EN
   assign abort_req = cmd_abort;
`else
   assign abort_req = 1'b0;
`endif

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cmd_ready_q  <= 1'b1;
         core_start_q <= 1'b0;
         core_k_q     <= 32'd0;
         base0_q      <= 2'd0;
         base1_q      <= 2'd0;
         remaining_q  <= '0;
         out_x_q      <= 32'd0;
         out_y_q      <= 32'd0;
         out_z_q      <= 32'd0;
         out_k_q      <= 32'd0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         run_done_q   <= 1'b0;
         abort_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cmd_ready_q  <= cmd_ready_d;
         core_start_q <= core_start_d;
         core_k_q     <= core_k_d;
         base0_q      <= base0_d;
         base1_q      <= base1_d;
         remaining_q  <= remaining_d;
         out_x_q      <= out_x_d;
         out_y_q      <= out_y_d;
         out_z_q      <= out_z_d;
         out_k_q      <= out_k_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
         run_done_q   <= run_done_d;
         abort_q      <= abort_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d      = state_q;
      cmd_ready_d  = cmd_ready_q;
      core_start_d = 1'b0;
      core_k_d     = core_k_q;
      base0_d      = base0_q;
      base1_d      = base1_q;
      remaining_d  = remaining_q;
      out_x_d      = out_x_q;
      out_y_d      = out_y_q;
      out_z_d      = out_z_q;
      out_k_d      = out_k_q;
      out_valid_d  = out_valid_q;
      out_last_d   = out_last_q;
      run_done_d   = 1'b0;
      abort_d      = abort_q;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               cmd_ready_d = 1'b0;
               core_k_d    = cmd_k0;
               base0_d     = cmd_base0;
               base1_d     = cmd_base1;
               remaining_d = cmd_count;
               abort_d     = 1'b0;
               if (cmd_count == '0) begin
                  state_d    = S_FIN;
                  run_done_d = 1'b1;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            if (abort_req) begin
               state_d    = S_FIN;
               run_done_d = 1'b1;
            end else if (core_ready) begin
               core_start_d = 1'b1;
               state_d      = S_WAIT;
            end
         end
         S_WAIT: begin
            if (abort_req) begin
               abort_d = 1'b1;
            end
            // An aborted point still waits for its result so the core is left idle
            if (core_done) begin
               if (abort_req || abort_q) begin
                  state_d    = S_FIN;
                  run_done_d = 1'b1;
               end else begin
                  out_x_d     = core_x;
                  out_y_d     = core_y;
                  out_z_d     = core_z;
                  out_k_d     = core_k_q;
                  out_last_d  = (remaining_q == W_CNT'(1));
                  out_valid_d = 1'b1;
                  state_d     = S_EMIT;
               end
            end
         end
         S_EMIT: begin
            if (abort_req) begin
               abort_d    = 1'b1;
               out_last_d = 1'b1;
            end
            if (out_ready) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               remaining_d = remaining_q - W_CNT'(1);
               if (out_last_q || abort_req || abort_q) begin
                  state_d    = S_FIN;
                  run_done_d = 1'b1;
               end else begin
                  core_k_d = core_k_q + 32'd1;
                  state_d  = S_ISSUE;
               end
            end
         end
         S_FIN: begin
            state_d     = S_IDLE;
            cmd_ready_d = 1'b1;
         end
         default: begin
            state_d     = S_IDLE;
            cmd_ready_d = 1'b1;
         end
      endcase
   end

   assign cmd_ready  = cmd_ready_q;
   assign core_start = core_start_q;
   assign core_k     = core_k_q;
   assign core_base0 = base0_q;
   assign core_base1 = base1_q;
   assign out_valid  = out_valid_q;
   assign out_x      = out_x_q;
   assign out_y      = out_y_q;
   assign out_z      = out_z_q;
   assign out_k      = out_k_q;
   assign out_last   = out_last_q;
   assign run_done   = run_done_q;

endmodule
